// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluSlt = 2'd2
  } alu_op_e;

  typedef enum logic [2:0] {
    ClsLw,
    ClsAddi,
    ClsAdd,
    ClsSlt,
    ClsBeq,
    ClsBne,
    ClsIllegal
  } instr_cls_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSlt   = 6'b101010;

  function automatic alu_op_e alu_op_for(instr_cls_e cls);
    case (cls)
      ClsBeq, ClsBne: return AluSub;
      ClsSlt:         return AluSlt;
      default:        return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_e cls
);

  always_comb begin
    cls = ClsIllegal;
    unique case (opcode)
      OpLw:    cls = ClsLw;
      OpAddiu: cls = ClsAddi;
      OpBeq:   cls = ClsBeq;
      OpBne:   cls = ClsBne;
      OpRtype: begin
        if (funct == FnAddu) begin
          cls = ClsAdd;
        end else if (funct == FnSlt) begin
          cls = ClsSlt;
        end
      end
      default: cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: sequences instruction fetch, decode and datapath strobes
// for one program run per start pulse.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned PROG_LEN = 11,
  parameter int unsigned PC_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instruction,
  input  logic            alu_zero,
  output logic [PC_W-1:0] prog_counter,
  output logic            ir_load,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            mem_read,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            wb_sel,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic            illegal_q;
  instr_cls_e      cls;
  logic            taken;
  logic [16:0]     next_pc;
  logic            next_ok;

  logic unused_ir;
  assign unused_ir = ^ir_q[25:16];

  mc_decode u_decode (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .cls    (cls)
  );

  // 17-bit two's complement so a backward branch past PC 0 shows up as negative.
  always_comb begin
    taken   = ((cls == ClsBeq) && alu_zero) || ((cls == ClsBne) && !alu_zero);
    next_pc = {{(17 - PC_W){1'b0}}, pc_q} + 17'd1 + (taken ? {ir_q[15], ir_q[15:0]} : 17'd0);
    next_ok = !next_pc[16] && (next_pc < 17'(PROG_LEN));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = (cls == ClsIllegal) ? StDone : StExec;
      StExec: begin
        unique case (cls)
          ClsLw:          state_d = StMem;
          ClsBeq, ClsBne: state_d = next_ok ? StFetch : StDone;
          default:        state_d = StWb;
        endcase
      end
      StMem:    state_d = StWb;
      StWb:     state_d = next_ok ? StFetch : StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      ir_load   <= 1'b0;
      alu_src   <= 1'b0;
      alu_op    <= AluAdd;
      mem_read  <= 1'b0;
      reg_write <= 1'b0;
      reg_dst   <= 1'b0;
      wb_sel    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        pc_q      <= '0;
        illegal_q <= 1'b0;
      end
      if (state_q == StFetch) begin
        ir_q <= instruction;
      end
      if (state_q == StDecode && cls == ClsIllegal) begin
        illegal_q <= 1'b1;
      end
      if ((state_q == StExec || state_q == StWb) && state_d == StFetch) begin
        pc_q <= next_pc[PC_W-1:0];
      end
      ir_load   <= (state_d == StDecode);
      alu_src   <= (state_d == StExec) && (cls == ClsLw || cls == ClsAddi);
      alu_op    <= (state_d == StExec) ? alu_op_for(cls) : AluAdd;
      mem_read  <= (state_d == StMem);
      reg_write <= (state_d == StWb);
      reg_dst   <= (state_d == StWb) && (cls == ClsAdd || cls == ClsSlt);
      wb_sel    <= (state_d == StWb) && (cls == ClsLw);
      busy      <= state_d inside {StFetch, StDecode, StExec, StMem, StWb};
      done      <= (state_d == StDone);
    end
  end

  assign prog_counter = pc_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle strobe/PC checks against hand-derived values.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [31:0] instruction;
  logic        alu_zero;
  logic [3:0]  prog_counter, prog_counter2;
  logic        ir_load, alu_src, mem_read, reg_write, reg_dst, wb_sel, busy, done, illegal;
  logic [1:0]  alu_op;
  logic        ir_load2, alu_src2, mem_read2, reg_write2, reg_dst2, wb_sel2, busy2, done2;
  logic        illegal2;
  logic [1:0]  alu_op2;

  logic [31:0] imem [16];
  logic [15:0] zero_map;
  int          total = 0;
  int          bad = 0;

  // {busy, done, illegal, ir_load, alu_src, alu_op[1:0], mem_read, reg_write, reg_dst, wb_sel}
  logic [10:0] sig, sig2;
  assign sig  = {busy, done, illegal, ir_load, alu_src, alu_op, mem_read, reg_write, reg_dst,
                 wb_sel};
  assign sig2 = {busy2, done2, illegal2, ir_load2, alu_src2, alu_op2, mem_read2, reg_write2,
                 reg_dst2, wb_sel2};

  localparam logic [10:0] SIdle    = 11'b000_0000_0000;
  localparam logic [10:0] SFetch   = 11'b100_0000_0000;
  localparam logic [10:0] SDec     = 11'b100_1000_0000;
  localparam logic [10:0] SExImm   = 11'b100_0100_0000;
  localparam logic [10:0] SExBr    = 11'b100_0001_0000;
  localparam logic [10:0] SExAdd   = 11'b100_0000_0000;
  localparam logic [10:0] SExSlt   = 11'b100_0010_0000;
  localparam logic [10:0] SMem     = 11'b100_0000_1000;
  localparam logic [10:0] SWbLw    = 11'b100_0000_0101;
  localparam logic [10:0] SWbI     = 11'b100_0000_0100;
  localparam logic [10:0] SWbR     = 11'b100_0000_0110;
  localparam logic [10:0] SDone    = 11'b010_0000_0000;
  localparam logic [10:0] SDoneIll = 11'b011_0000_0000;
  localparam logic [10:0] SIdleIll = 11'b001_0000_0000;

  localparam logic [31:0] IBeq5   = 32'h1000_0005;
  localparam logic [31:0] IBne1   = 32'h1400_0001;
  localparam logic [31:0] IBneM3  = 32'h1400_FFFD;
  localparam logic [31:0] IAddiu  = 32'h2400_0007;
  localparam logic [31:0] IAddu   = 32'h0000_0021;
  localparam logic [31:0] ISlt    = 32'h0000_002A;
  localparam logic [31:0] ILw     = 32'h8C00_0004;
  localparam logic [31:0] IBad    = 32'hFC00_0000;

  assign instruction = imem[prog_counter];
  assign alu_zero    = zero_map[prog_counter];

  always #5 clk = ~clk;

  mc_controller #(.PROG_LEN(11), .PC_W(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .instruction  (instruction),
    .alu_zero     (alu_zero),
    .prog_counter (prog_counter),
    .ir_load      (ir_load),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .mem_read     (mem_read),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
  );

  mc_controller #(.PROG_LEN(1), .PC_W(4)) u_dut_short (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start2),
    .instruction  (ILw),
    .alu_zero     (1'b0),
    .prog_counter (prog_counter2),
    .ir_load      (ir_load2),
    .alu_src      (alu_src2),
    .alu_op       (alu_op2),
    .mem_read     (mem_read2),
    .reg_write    (reg_write2),
    .reg_dst      (reg_dst2),
    .wb_sel       (wb_sel2),
    .busy         (busy2),
    .done         (done2),
    .illegal      (illegal2)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    zero_map = '0;
    for (int i = 0; i < 16; i++) imem[i] = IBad;
    step(2);
    chk("reset_sig", 32'(sig), 32'(SIdle));
    chk("reset_pc", 32'(prog_counter), 32'd0);
    chk("reset_sig_short", 32'(sig2), 32'(SIdle));
    rst_n = 1'b1;
    step();

    // lw with PROG_LEN=1, start held high throughout
    start2 = 1'b1;
    step(); chk("lw_c1_fetch", 32'(sig2), 32'(SFetch));
    step(); chk("lw_c2_decode", 32'(sig2), 32'(SDec));
    step(); chk("lw_c3_exec", 32'(sig2), 32'(SExImm));
    step(); chk("lw_c4_mem", 32'(sig2), 32'(SMem));
    step(); chk("lw_c5_wb", 32'(sig2), 32'(SWbLw));
    step(); chk("lw_c6_done", 32'(sig2), 32'(SDone));
    chk("lw_c6_pc", 32'(prog_counter2), 32'd0);
    step(); chk("lw_c7_idle", 32'(sig2), 32'(SIdle));
    step(); chk("lw_c8_restart", 32'(sig2), 32'(SFetch));
    start2 = 1'b0;

    // beq at PC 6, taken to 12: out of range, PC stays 6
    imem[0] = IBeq5; zero_map[0] = 1'b1;
    imem[6] = IBeq5; zero_map[6] = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    chk("a_c1_sig", 32'(sig), 32'(SFetch));
    chk("a_c1_pc", 32'(prog_counter), 32'd0);
    step(2); chk("a_c3_exec_br", 32'(sig), 32'(SExBr));
    step(); chk("a_c4_pc", 32'(prog_counter), 32'd6);
    chk("a_c4_sig", 32'(sig), 32'(SFetch));
    step(3); chk("a_c7_done", 32'(sig), 32'(SDone));
    chk("a_c7_pc", 32'(prog_counter), 32'd6);
    step(); chk("a_c8_idle", 32'(sig), 32'(SIdle));

    // beq not taken, addiu, bne forward, bne backward, bne falls off the end
    zero_map[6] = 1'b0;
    imem[7] = IAddiu;
    imem[8] = IBne1;  zero_map[8] = 1'b0;
    imem[10] = IBneM3; zero_map[10] = 1'b0;
    start = 1'b1;
    step(); start = 1'b0;
    step(6); chk("b_c7_pc", 32'(prog_counter), 32'd7);
    step(2); chk("b_c9_exec_addiu", 32'(sig), 32'(SExImm));
    step(); chk("b_c10_wb_addiu", 32'(sig), 32'(SWbI));
    step(); chk("b_c11_pc", 32'(prog_counter), 32'd8);
    step(3); chk("b_c14_pc", 32'(prog_counter), 32'd10);
    step(3); chk("b_c17_pc_back", 32'(prog_counter), 32'd8);
    zero_map[10] = 1'b1;
    step(3); chk("b_c20_pc", 32'(prog_counter), 32'd10);
    step(3); chk("b_c23_done", 32'(sig), 32'(SDone));
    chk("b_c23_pc", 32'(prog_counter), 32'd10);
    step(); chk("b_c24_idle", 32'(sig), 32'(SIdle));

    // illegal word at PC 0
    imem[0] = IBad;
    start = 1'b1;
    step(); start = 1'b0;
    step(); chk("c_c2_decode", 32'(sig), 32'(SDec));
    step(); chk("c_c3_done_ill", 32'(sig), 32'(SDoneIll));
    step(); chk("c_c4_idle_sticky", 32'(sig), 32'(SIdleIll));

    // addu, slt, lw; reset during lw MEM
    imem[0] = IAddu; imem[1] = ISlt; imem[2] = ILw;
    start = 1'b1;
    step(); start = 1'b0;
    chk("d_c1_ill_cleared", 32'(sig), 32'(SFetch));
    step(2); chk("d_c3_exec_addu", 32'(sig), 32'(SExAdd));
    step(); chk("d_c4_wb_r", 32'(sig), 32'(SWbR));
    step(); chk("d_c5_pc", 32'(prog_counter), 32'd1);
    step(2); chk("d_c7_exec_slt", 32'(sig), 32'(SExSlt));
    step(); chk("d_c8_wb_r", 32'(sig), 32'(SWbR));
    step(); chk("d_c9_pc", 32'(prog_counter), 32'd2);
    step(2); chk("d_c11_exec_lw", 32'(sig), 32'(SExImm));
    step(); chk("d_c12_mem", 32'(sig), 32'(SMem));
    rst_n = 1'b0;
    step(); chk("d_rst_sig", 32'(sig), 32'(SIdle));
    chk("d_rst_pc", 32'(prog_counter), 32'd0);
    rst_n = 1'b1;
    step(); chk("d_after_rst_no_done", 32'(sig), 32'(SIdle));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
